// File: rtl/fip_pkg.sv
// Shared fixed-point package for the fip_32 family.
// Contents:
//   TRUE / FALSE      single-bit boolean constants
//   FIP_MIN / FIP_MAX range limits of an unsigned 32-bit fixed-point word
//   sqrt_state_t      state encoding of the sequential square-root FSM
package fip_pkg;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    localparam logic [31:0] FIP_MIN = 32'h0000_0000;
    localparam logic [31:0] FIP_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_CALC = 2'd1,
        SQ_DONE = 2'd2
    } sqrt_state_t;

endpackage

// File: rtl/fip_sqrt_step.sv
// One digit-by-digit square-root iteration, purely combinational.
// Brings down the next two radicand bits, attempts to subtract the trial
// value {q, 01} and appends the resulting root bit to q.
// Ports:
//   rem       in  N+2  partial remainder
//   q         in  N    partial root
//   bits      in  2    next two radicand bits (MSB first)
//   rem_next  out N+2  updated remainder
//   q_next    out N    updated root (q shifted left, new bit in LSB)
module fip_sqrt_step #(
    parameter int N = 24
) (
    input  logic [N+1:0] rem,
    input  logic [N-1:0] q,
    input  logic [1:0]   bits,
    output logic [N+1:0] rem_next,
    output logic [N-1:0] q_next
);

    logic [N+3:0] r_trial;
    logic [N+3:0] t_val;
    logic [N+3:0] diff;
    logic         take;
    // The top two bits of both candidates are provably zero (the remainder
    // never exceeds twice the partial root), so they are dropped.
    logic [3:0]   unused_hi;

    assign r_trial   = {rem, bits};
    assign t_val     = {2'b00, q, 2'b01};
    assign diff      = r_trial - t_val;
    assign take      = (r_trial >= t_val);
    assign unused_hi = {diff[N+3:N+2], r_trial[N+3:N+2]};

    assign rem_next = take ? diff[N+1:0] : r_trial[N+1:0];
    assign q_next   = {q[N-2:0], take};

endmodule

// File: rtl/fip_32_sqrt_seq.sv
// Iterative fixed-point square root, one root bit per clock.
// Returns floor(sqrt(i_rad * 2^FRA_BITS)) in the same Q format as i_rad.
// Ports:
//   i_clk    in   1   clock
//   i_rst    in   1   synchronous active-high reset
//   i_en     in   1   start request, accepted when not busy (IDLE or DONE)
//   i_rad    in  32   unsigned radicand, sampled on the accept edge only
//   o_root   out 32   floored root, held until the next result
//   o_exact  out  1   remainder was zero, qualified by o_valid
//   o_busy   out  1   operation in flight
//   o_valid  out  1   one-cycle result strobe
module fip_32_sqrt_seq
    import fip_pkg::*;
#(
    parameter int FRA_BITS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [31:0] i_rad,
    output logic [31:0] o_root,
    output logic        o_exact,
    output logic        o_busy,
    output logic        o_valid
);

    localparam int EXT   = 32 + FRA_BITS;
    localparam int N     = EXT / 2;
    localparam int CNT_W = $clog2(N);

    generate
        if ((FRA_BITS % 2) != 0 || FRA_BITS < 0 || FRA_BITS > 32) begin : g_bad_fra
            $error("fip_32_sqrt_seq: FRA_BITS must be even and within 0..32");
        end
    endgenerate

    sqrt_state_t       state_reg, state_next;
    logic [EXT-1:0]    rad_sr_reg;
    logic [N+1:0]      rem_reg;
    logic [N-1:0]      q_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:0]       root_reg;
    logic              exact_reg;

    logic [N+1:0]      rem_step;
    logic [N-1:0]      q_step;
    logic              accept;
    logic              last_iter;

    fip_sqrt_step #(.N(N)) u_step (
        .rem      (rem_reg),
        .q        (q_reg),
        .bits     (rad_sr_reg[EXT-1:EXT-2]),
        .rem_next (rem_step),
        .q_next   (q_step)
    );

    // A new operation can start from IDLE or straight out of DONE.
    assign accept    = i_en && (state_reg != SQ_CALC);
    assign last_iter = (state_reg == SQ_CALC) && (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SQ_IDLE: if (i_en) state_next = SQ_CALC;
            SQ_CALC: if (cnt_reg == '0) state_next = SQ_DONE;
            SQ_DONE: state_next = i_en ? SQ_CALC : SQ_IDLE;
            default: state_next = SQ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= SQ_IDLE;
            rad_sr_reg <= '0;
            rem_reg    <= '0;
            q_reg      <= '0;
            cnt_reg    <= '0;
            root_reg   <= '0;
            exact_reg  <= FALSE;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // X = i_rad * 2^FRA_BITS, so the integer root lands in Q format
                rad_sr_reg <= EXT'(i_rad) << FRA_BITS;
                rem_reg    <= '0;
                q_reg      <= '0;
                cnt_reg    <= CNT_W'(N - 1);
            end else if (state_reg == SQ_CALC) begin
                rad_sr_reg <= rad_sr_reg << 2;
                rem_reg    <= rem_step;
                q_reg      <= q_step;
                if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end
            // Result registers are written as the FSM enters DONE.
            if (last_iter) begin
                root_reg  <= 32'(q_step);
                exact_reg <= (rem_step == '0);
            end
        end
    end

    assign o_root  = root_reg;
    assign o_exact = exact_reg;
    assign o_busy  = (state_reg == SQ_CALC);
    assign o_valid = (state_reg == SQ_DONE);

endmodule
